rggen_register_access_arbiter: RTL and testbench

Shares a single register-block access port between `N` bus-side requesters, e.g. a host bus bridge and a debug port. Each winning requester gets one complete, non-overlapping transaction: capture, downstream access, then response. Bit-field write-mask semantics are preserved end to end. The block sits between the bus adapters and the register/bit-field decode logic.

---
 rtl/rggen_register_access_arbiter_if.sv | 68 ++++++
 rtl/rggen_register_access_arbiter.sv | 143 ++++++++++++++
 tb/tb_rggen_register_access_arbiter.sv | 526 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_register_access_arbiter_if.sv
// Bus bundle between N requesters, the arbiter and the register block.
// Ports: requests, per-requester responses, downstream access channel.
interface rggen_register_access_arbiter_if #(
  parameter int N             = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic [N-1:0]                    i_request_valid;
  logic [N-1:0]                    i_request_write;
  logic [N-1:0][ADDRESS_WIDTH-1:0] i_request_address;
  logic [N-1:0][DATA_WIDTH-1:0]    i_request_write_data;
  logic [N-1:0][DATA_WIDTH-1:0]    i_request_write_mask;
  logic [N-1:0]                    o_request_ready;
  logic [N-1:0]                    o_response_valid;
  logic [N-1:0]                    i_response_ready;
  logic [DATA_WIDTH-1:0]           o_response_read_data;
  logic                            o_response_error;
  logic                            o_access_valid;
  logic                            o_access_write;
  logic [ADDRESS_WIDTH-1:0]        o_access_address;
  logic [DATA_WIDTH-1:0]           o_access_write_data;
  logic [DATA_WIDTH-1:0]           o_access_write_mask;
  logic                            i_access_done;
  logic [DATA_WIDTH-1:0]           i_access_read_data;
  logic                            i_access_error;

  modport slave (
    input  i_request_valid,
    input  i_request_write,
    input  i_request_address,
    input  i_request_write_data,
    input  i_request_write_mask,
    output o_request_ready,
    output o_response_valid,
    input  i_response_ready,
    output o_response_read_data,
    output o_response_error,
    output o_access_valid,
    output o_access_write,
    output o_access_address,
    output o_access_write_data,
    output o_access_write_mask,
    input  i_access_done,
    input  i_access_read_data,
    input  i_access_error
  );

  modport master (
    output i_request_valid,
    output i_request_write,
    output i_request_address,
    output i_request_write_data,
    output i_request_write_mask,
    input  o_request_ready,
    input  o_response_valid,
    output i_response_ready,
    input  o_response_read_data,
    input  o_response_error,
    input  o_access_valid,
    input  o_access_write,
    input  o_access_address,
    input  o_access_write_data,
    input  o_access_write_mask,
    output i_access_done,
    output i_access_read_data,
    output i_access_error
  );
endinterface

// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter sharing one register access port among N requesters.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of the bundle).
module rggen_register_access_arbiter #(
  parameter int N              = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst_n,
  rggen_register_access_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] RESPONSE = 2'd2;
  localparam logic [N-1:0] ONE = N'(1);

  logic [1:0]               r_state;
  logic [IW-1:0]            r_pointer;
  logic [IW-1:0]            r_grant;
  logic [15:0]              r_count;
  logic                     r_access_valid;
  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0]    r_write_data;
  logic [DATA_WIDTH-1:0]    r_write_mask;
  logic [N-1:0]             r_response_valid;
  logic [DATA_WIDTH-1:0]    r_read_data;
  logic                     r_error;

  logic          w_found;
  logic [IW-1:0] w_index;
  logic [IW-1:0] w_next_pointer;
  logic [N-1:0]  w_request_ready;
  logic          w_grant;
  logic          w_done;
  logic          w_timeout;
  logic          w_ack;

  // Scan from the priority pointer upward, wrapping at N-1.
  always_comb begin : search
    logic [IW:0] v_sum;
    w_found = 1'b0;
    w_index = '0;
    v_sum   = '0;
    for (int i = 0; i < N; i++) begin
      v_sum = {1'b0, r_pointer} + (IW+1)'(i);
      if (v_sum >= (IW+1)'(N))
        v_sum = v_sum - (IW+1)'(N);
      if (!w_found && bus.i_request_valid[v_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_index = v_sum[IW-1:0];
      end
    end
  end

  assign w_next_pointer =
    (w_index == IW'(N-1)) ? '0 : w_index + 1'b1;

  // No grant while reset is asserted: it would be lost.
  assign w_grant = rst_n && (r_state == IDLE) && w_found;
  assign w_request_ready = w_grant ? (ONE << w_index) : '0;

  assign w_done = (r_state == ACCESS) && bus.i_access_done;
  assign w_timeout =
    (r_state == ACCESS) && !bus.i_access_done &&
    (TIMEOUT != 16'd0) && (r_count == TIMEOUT);
  assign w_ack =
    (r_state == RESPONSE) && bus.i_response_ready[r_grant];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_pointer        <= '0;
      r_grant          <= '0;
      r_count          <= '0;
      r_access_valid   <= 1'b0;
      r_write          <= 1'b0;
      r_address        <= '0;
      r_write_data     <= '0;
      r_write_mask     <= '0;
      r_response_valid <= '0;
      r_read_data      <= '0;
      r_error          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state        <= ACCESS;
            r_grant        <= w_index;
            r_pointer      <= w_next_pointer;
            r_count        <= '0;
            r_access_valid <= 1'b1;
            r_write        <= bus.i_request_write[w_index];
            r_address      <= bus.i_request_address[w_index];
            r_write_data   <= bus.i_request_write_data[w_index];
            // Reads never carry a write mask downstream.
            r_write_mask   <=
              bus.i_request_write[w_index] ?
              bus.i_request_write_mask[w_index] : '0;
          end
        end
        ACCESS: begin
          if (w_done) begin
            r_state          <= RESPONSE;
            r_access_valid   <= 1'b0;
            r_response_valid <= ONE << r_grant;
            r_read_data      <=
              r_write ? '0 : bus.i_access_read_data;
            r_error          <= bus.i_access_error;
          end else if (w_timeout) begin
            r_state          <= RESPONSE;
            r_access_valid   <= 1'b0;
            r_response_valid <= ONE << r_grant;
            r_read_data      <= '0;
            r_error          <= 1'b1;
          end else begin
            r_count <= r_count + 16'd1;
          end
        end
        RESPONSE: begin
          if (w_ack) begin
            r_state          <= IDLE;
            r_response_valid <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_request_ready      = w_request_ready;
  assign bus.o_response_valid     = r_response_valid;
  assign bus.o_response_read_data = r_read_data;
  assign bus.o_response_error     = r_error;
  assign bus.o_access_valid       = r_access_valid;
  assign bus.o_access_write       = r_write;
  assign bus.o_access_address     = r_address;
  assign bus.o_access_write_data  = r_write_data;
  assign bus.o_access_write_mask  = r_write_mask;
endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Directed bench for rggen_register_access_arbiter (N=2, timeout 4).
// Ports: none; drives the bus bundle and the clock/reset.
module tb_rggen_register_access_arbiter;
  logic clk;
  logic rst_n;
  int n_checks;
  int n_fail;

  rggen_register_access_arbiter_if #(
    .N(2), .ADDRESS_WIDTH(16), .DATA_WIDTH(32)
  ) bus ();

  rggen_register_access_arbiter #(
    .N(2), .ADDRESS_WIDTH(16), .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.o_request_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_req_ready got %b want 00", bus.o_request_ready);
    end
    n_checks++;
    if (bus.o_response_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_rsp_valid got %b want 00", bus.o_response_valid);
    end
    n_checks++;
    if (bus.o_response_read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rsp_data got %h want 0", bus.o_response_read_data);
    end
    n_checks++;
    if (bus.o_response_error !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rsp_err got %b want 0", bus.o_response_error);
    end
    n_checks++;
    if (bus.o_access_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_acc_valid got %b want 0", bus.o_access_valid);
    end
    n_checks++;
    if (bus.o_access_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_acc_write got %b want 0", bus.o_access_write);
    end
    n_checks++;
    if (bus.o_access_address !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_acc_addr got %h want 0", bus.o_access_address);
    end
    n_checks++;
    if (bus.o_access_write_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_acc_wdata got %h want 0", bus.o_access_write_data);
    end
    n_checks++;
    if (bus.o_access_write_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_acc_mask got %h want 0", bus.o_access_write_mask);
    end
  endtask

  task automatic test_single_read;
    nxt();
    bus.i_request_valid         = 2'b01;
    bus.i_request_write         = 2'b00;
    bus.i_request_address[0]    = 16'h0010;
    bus.i_request_write_data[0] = 32'hDEAD_0000;
    bus.i_request_write_mask[0] = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (bus.o_request_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rd_ready got %b want 01", bus.o_request_ready);
    end
    nxt();
    bus.i_request_valid = 2'b00;
    #1;
    n_checks++;
    if (bus.o_access_valid !== 1'b1 || bus.o_access_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_acc got v=%b w=%b want v=1 w=0",
               bus.o_access_valid, bus.o_access_write);
    end
    n_checks++;
    if (bus.o_access_address !== 16'h0010) begin
      n_fail++;
      $display("FAIL rd_addr got %h want 0010", bus.o_access_address);
    end
    n_checks++;
    if (bus.o_access_write_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_mask1 got %h want 0", bus.o_access_write_mask);
    end
    nxt();
    #1;
    n_checks++;
    if (bus.o_access_valid !== 1'b1 || bus.o_access_write_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_acc2 got v=%b m=%h want v=1 m=0",
               bus.o_access_valid, bus.o_access_write_mask);
    end
    bus.i_access_done      = 1'b1;
    bus.i_access_read_data = 32'hA5A5_0001;
    bus.i_access_error     = 1'b0;
    nxt();
    bus.i_access_done      = 1'b0;
    bus.i_access_read_data = 32'h0;
    #1;
    n_checks++;
    if (bus.o_response_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL rd_rsp_valid got %b want 01", bus.o_response_valid);
    end
    n_checks++;
    if (bus.o_response_read_data !== 32'hA5A5_0001 ||
        bus.o_response_error !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_rsp got d=%h e=%b want d=a5a50001 e=0",
               bus.o_response_read_data, bus.o_response_error);
    end
    n_checks++;
    if (bus.o_access_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_acc_drop got %b want 0", bus.o_access_valid);
    end
    bus.i_response_ready = 2'b01;
    nxt();
    bus.i_response_ready = 2'b00;
    #1;
    n_checks++;
    if (bus.o_response_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_rsp_done got %b want 00", bus.o_response_valid);
    end
  endtask

  task automatic test_single_write;
    nxt();
    bus.i_request_valid         = 2'b10;
    bus.i_request_write         = 2'b10;
    bus.i_request_address[1]    = 16'h0020;
    bus.i_request_write_data[1] = 32'h1234_5678;
    bus.i_request_write_mask[1] = 32'h0000_FFFF;
    #1;
    n_checks++;
    if (bus.o_request_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_ready got %b want 10", bus.o_request_ready);
    end
    nxt();
    bus.i_request_valid = 2'b00;
    bus.i_request_write = 2'b00;
    #1;
    n_checks++;
    if (bus.o_access_valid !== 1'b1 || bus.o_access_write !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_acc got v=%b w=%b want v=1 w=1",
               bus.o_access_valid, bus.o_access_write);
    end
    n_checks++;
    if (bus.o_access_write_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL wr_data got %h want 12345678", bus.o_access_write_data);
    end
    n_checks++;
    if (bus.o_access_write_mask !== 32'h0000_FFFF) begin
      n_fail++;
      $display("FAIL wr_mask got %h want 0000ffff", bus.o_access_write_mask);
    end
    n_checks++;
    if (bus.o_access_address !== 16'h0020) begin
      n_fail++;
      $display("FAIL wr_addr got %h want 0020", bus.o_access_address);
    end
    bus.i_access_done      = 1'b1;
    bus.i_access_read_data = 32'hFFFF_FFFF;
    nxt();
    bus.i_access_done      = 1'b0;
    bus.i_access_read_data = 32'h0;
    #1;
    n_checks++;
    if (bus.o_response_valid !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_rsp_valid got %b want 10", bus.o_response_valid);
    end
    n_checks++;
    if (bus.o_response_read_data !== 32'h0 ||
        bus.o_response_error !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rsp got d=%h e=%b want d=0 e=0",
               bus.o_response_read_data, bus.o_response_error);
    end
    bus.i_response_ready = 2'b10;
    nxt();
    bus.i_response_ready = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_rdy [12];
    logic [1:0] exp_rsp [12];
    exp_rdy = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    exp_rsp = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10,
                2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    bus.i_request_valid      = 2'b11;
    bus.i_request_write      = 2'b00;
    bus.i_request_address[0] = 16'h0100;
    bus.i_request_address[1] = 16'h0200;
    bus.i_access_done        = 1'b1;
    bus.i_response_ready     = 2'b11;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_checks++;
      if (bus.o_request_ready !== exp_rdy[i]) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d] got %b want %b",
                 i, bus.o_request_ready, exp_rdy[i]);
      end
      n_checks++;
      if (bus.o_response_valid !== exp_rsp[i]) begin
        n_fail++;
        $display("FAIL b2b_rsp[%0d] got %b want %b",
                 i, bus.o_response_valid, exp_rsp[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (bus.o_access_address !== 16'h0200) begin
          n_fail++;
          $display("FAIL b2b_addr got %h want 0200", bus.o_access_address);
        end
      end
      if (i < 11) nxt();
    end
    bus.i_request_valid = 2'b00;
    nxt();
    bus.i_access_done    = 1'b0;
    bus.i_response_ready = 2'b00;
    #1;
    n_checks++;
    if (bus.o_response_valid !== 2'b00 || bus.o_access_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle got r=%b a=%b want r=00 a=0",
               bus.o_response_valid, bus.o_access_valid);
    end
  endtask

  task automatic test_timeout;
    nxt();
    bus.i_request_valid      = 2'b01;
    bus.i_request_write      = 2'b00;
    bus.i_request_address[0] = 16'h0030;
    bus.i_access_read_data   = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (bus.o_request_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL to_ready got %b want 01", bus.o_request_ready);
    end
    nxt();
    bus.i_request_valid = 2'b00;
    #1;
    n_checks++;
    if (bus.o_access_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL to_acc got %b want 1", bus.o_access_valid);
    end
    for (int k = 1; k <= 4; k++) begin
      nxt();
      #1;
      n_checks++;
      if (bus.o_response_valid !== 2'b00 || bus.o_access_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL to_wait[%0d] got r=%b a=%b want r=00 a=1",
                 k, bus.o_response_valid, bus.o_access_valid);
      end
    end
    nxt();
    #1;
    n_checks++;
    if (bus.o_response_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL to_rsp_valid got %b want 01", bus.o_response_valid);
    end
    n_checks++;
    if (bus.o_response_read_data !== 32'h0 ||
        bus.o_response_error !== 1'b1) begin
      n_fail++;
      $display("FAIL to_rsp got d=%h e=%b want d=0 e=1",
               bus.o_response_read_data, bus.o_response_error);
    end
    bus.i_response_ready = 2'b01;
    nxt();
    bus.i_response_ready     = 2'b00;
    bus.i_request_valid      = 2'b10;
    bus.i_request_address[1] = 16'h0034;
    #1;
    n_checks++;
    if (bus.o_request_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL tc_ready got %b want 10", bus.o_request_ready);
    end
    nxt();
    bus.i_request_valid = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      nxt();
      #1;
      n_checks++;
      if (bus.o_response_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL tc_wait[%0d] got %b want 00",
                 k, bus.o_response_valid);
      end
    end
    nxt();
    bus.i_access_done      = 1'b1;
    bus.i_access_read_data = 32'hCAFE_F00D;
    bus.i_access_error     = 1'b0;
    nxt();
    bus.i_access_done      = 1'b0;
    bus.i_access_read_data = 32'h0;
    #1;
    n_checks++;
    if (bus.o_response_valid !== 2'b10) begin
      n_fail++;
      $display("FAIL tc_rsp_valid got %b want 10", bus.o_response_valid);
    end
    n_checks++;
    if (bus.o_response_read_data !== 32'hCAFE_F00D ||
        bus.o_response_error !== 1'b0) begin
      n_fail++;
      $display("FAIL tc_rsp got d=%h e=%b want d=cafef00d e=0",
               bus.o_response_read_data, bus.o_response_error);
    end
    bus.i_response_ready = 2'b10;
    nxt();
    bus.i_response_ready = 2'b00;
  endtask

  task automatic test_backpressure;
    nxt();
    bus.i_request_valid      = 2'b01;
    bus.i_request_write      = 2'b00;
    bus.i_request_address[0] = 16'h0040;
    #1;
    n_checks++;
    if (bus.o_request_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_ready0 got %b want 01", bus.o_request_ready);
    end
    nxt();
    bus.i_request_valid      = 2'b10;
    bus.i_request_address[1] = 16'h0044;
    bus.i_access_done        = 1'b1;
    bus.i_access_read_data   = 32'h5A5A_0F0F;
    nxt();
    bus.i_access_done      = 1'b0;
    bus.i_access_read_data = 32'hFFFF_FFFF;
    bus.i_response_ready   = 2'b10;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (bus.o_response_valid !== 2'b01 ||
          bus.o_response_read_data !== 32'h5A5A_0F0F ||
          bus.o_request_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got r=%b d=%h q=%b want r=01 d=5a5a0f0f q=00",
                 k, bus.o_response_valid, bus.o_response_read_data,
                 bus.o_request_ready);
      end
      nxt();
    end
    bus.i_response_ready = 2'b01;
    #1;
    n_checks++;
    if (bus.o_response_valid !== 2'b01 || bus.o_request_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_hs got r=%b q=%b want r=01 q=00",
               bus.o_response_valid, bus.o_request_ready);
    end
    nxt();
    bus.i_response_ready = 2'b00;
    #1;
    n_checks++;
    if (bus.o_request_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_ready1 got %b want 10", bus.o_request_ready);
    end
    nxt();
    bus.i_request_valid = 2'b00;
    bus.i_access_done   = 1'b1;
    nxt();
    bus.i_access_done    = 1'b0;
    bus.i_response_ready = 2'b10;
    nxt();
    bus.i_response_ready = 2'b00;
  endtask

  task automatic test_reset_mid_access;
    nxt();
    bus.i_request_valid         = 2'b01;
    bus.i_request_write         = 2'b01;
    bus.i_request_address[0]    = 16'h0050;
    bus.i_request_write_data[0] = 32'h0000_0011;
    bus.i_request_write_mask[0] = 32'h0000_000F;
    #1;
    n_checks++;
    if (bus.o_request_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rm_ready0 got %b want 01", bus.o_request_ready);
    end
    nxt();
    bus.i_request_valid = 2'b10;
    bus.i_request_write = 2'b00;
    #1;
    n_checks++;
    if (bus.o_access_valid !== 1'b1 || bus.o_access_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_acc got v=%b w=%b want v=1 w=1",
               bus.o_access_valid, bus.o_access_write);
    end
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    bus.i_request_valid = 2'b11;
    #1;
    n_checks++;
    if (bus.o_access_valid !== 1'b0 || bus.o_access_write !== 1'b0 ||
        bus.o_access_address !== 16'h0 ||
        bus.o_access_write_data !== 32'h0 ||
        bus.o_access_write_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_acc_clr got v=%b w=%b a=%h d=%h m=%h want all 0",
               bus.o_access_valid, bus.o_access_write,
               bus.o_access_address, bus.o_access_write_data,
               bus.o_access_write_mask);
    end
    n_checks++;
    if (bus.o_response_valid !== 2'b00 ||
        bus.o_response_read_data !== 32'h0 ||
        bus.o_response_error !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_rsp_clr got r=%b d=%h e=%b want all 0",
               bus.o_response_valid, bus.o_response_read_data,
               bus.o_response_error);
    end
    n_checks++;
    if (bus.o_request_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rm_ptr got %b want 01", bus.o_request_ready);
    end
    nxt();
    bus.i_request_valid = 2'b10;
    bus.i_access_done   = 1'b1;
    nxt();
    bus.i_access_done    = 1'b0;
    bus.i_response_ready = 2'b01;
    #1;
    n_checks++;
    if (bus.o_response_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL rm_rsp got %b want 01", bus.o_response_valid);
    end
    nxt();
    bus.i_response_ready = 2'b00;
    #1;
    n_checks++;
    if (bus.o_request_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL rm_ready1 got %b want 10", bus.o_request_ready);
    end
    nxt();
    bus.i_request_valid = 2'b00;
    bus.i_access_done   = 1'b1;
    nxt();
    bus.i_access_done    = 1'b0;
    bus.i_response_ready = 2'b10;
    nxt();
    bus.i_response_ready = 2'b00;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.i_request_valid      = '0;
    bus.i_request_write      = '0;
    bus.i_request_address    = '0;
    bus.i_request_write_data = '0;
    bus.i_request_write_mask = '0;
    bus.i_response_ready     = '0;
    bus.i_access_done        = 1'b0;
    bus.i_access_read_data   = '0;
    bus.i_access_error       = 1'b0;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
